// File: rtl/mul_pkg.sv
// mul_pkg: shared rounding-mode and exception-flag types for the multiplier datapath
package mul_pkg;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4} rnd_mode_t;
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } mul_flags_t;
endpackage

// File: rtl/mul_round_incr.sv
// mul_round_incr: IEEE-754 round-increment decision; reserved mode codes round to nearest even
module mul_round_incr
  import mul_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  input  logic [2:0] rm,
  output logic       inc,
  output logic       inexact
);
  always_comb begin
    inexact = g | s;
    inc = rm == RTZ ? 1'b0 :
          rm == RDN ? sign & inexact :
          rm == RUP ? !sign & inexact :
          rm == RMM ? g : g & (s | lsb);
  end
endmodule

// File: rtl/mul_round_pack.sv
// mul_round_pack: 2-stage round/pack pipeline; define MUL_ROUND_PACK_SKID_EN for a registered-ready 2-entry output skid buffer
module mul_round_pack
  import mul_pkg::*;
#(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [EXPO_W+1:0]          in_expo,
  input  logic [2*MANT_W+1:0]        in_mant,
  input  logic                       in_uflow,
  input  logic                       in_sticky,
  input  logic [2:0]                 in_rm,
  input  logic                       in_byp,
  input  logic [EXPO_W+MANT_W:0]     in_byp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXPO_W+MANT_W:0]     out_result,
  output logic [2:0]                 out_flags
);
  localparam int W = 1 + EXPO_W + MANT_W;
  typedef struct packed {
    logic              sign;
    logic [EXPO_W+1:0] expo;
    logic [MANT_W:0]   mant;
    logic              inc;
    logic              gs;
    logic              uflow;
    logic              byp;
    logic [W-1:0]      byp_data;
    logic [2:0]        rm;
  } s1_t;
  typedef struct packed {
    logic [W-1:0] res;
    mul_flags_t   flags;
  } s2_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q, s2_n;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic s1_en, s2_en, inc, gs, ovf, to_max;
  logic [MANT_W+1:0] sum;
  logic [EXPO_W+1:0] expo_r;
  mul_round_incr u_incr (
    .sign    (in_sign),
    .lsb     (in_mant[MANT_W]),
    .g       (in_mant[MANT_W-1]),
    .s       (|in_mant[MANT_W-2:0] | in_sticky),
    .rm      (in_rm),
    .inc     (inc),
    .inexact (gs)
  );
  always_comb begin
    sum = {1'b0, s1_q.mant} + {{(MANT_W+1){1'b0}}, s1_q.inc};
    expo_r = sum[MANT_W+1] ? s1_q.expo + (EXPO_W+2)'(1) :
             (s1_q.expo == '0 && sum[MANT_W]) ? (EXPO_W+2)'(1) : s1_q.expo;
    ovf = s1_q.expo[EXPO_W+1] || expo_r >= (EXPO_W+2)'((1 << EXPO_W) - 1);
    to_max = s1_q.rm == RTZ || (s1_q.rm == RDN && !s1_q.sign) || (s1_q.rm == RUP && s1_q.sign);
    s2_n.res = s1_q.byp ? s1_q.byp_data :
               !ovf ? {s1_q.sign, expo_r[EXPO_W-1:0], sum[MANT_W-1:0]} :
               to_max ? {s1_q.sign, {(EXPO_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}} :
               {s1_q.sign, {EXPO_W{1'b1}}, {MANT_W{1'b0}}};
    s2_n.flags = s1_q.byp ? '0 : mul_flags_t'{overflow: ovf, underflow: s1_q.uflow & s1_q.gs, inexact: s1_q.gs | ovf};
    s1_en = !s1_valid_q || s2_en;
    s1_valid_d = s1_en ? in_valid && in_ready : s1_valid_q;
    s1_d = s1_en ? s1_t'{sign: in_sign, expo: in_expo,
                         mant: {in_mant[2*MANT_W+1] | in_mant[2*MANT_W], in_mant[2*MANT_W-1:MANT_W]},
                         inc: inc, gs: gs, uflow: in_uflow, byp: in_byp, byp_data: in_byp_data, rm: in_rm} : s1_q;
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
    s2_d = s2_en ? s2_n : s2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end
`ifdef MUL_ROUND_PACK_SKID_EN
  s2_t fifo_d [2];
  s2_t fifo_q [2];
  logic [1:0] cnt_d, cnt_q, cnt_p;
  logic pop, direct, push;
  always_comb begin
    pop = cnt_q != 2'd0 && out_ready;
    direct = s2_valid_q && cnt_q == 2'd0 && out_ready;
    push = s2_valid_q && !direct && (cnt_q != 2'd2 || pop);
    s2_en = !s2_valid_q || direct || push;
    cnt_p = cnt_q - {1'b0, pop};
    fifo_d = fifo_q;
    if (pop) fifo_d[0] = fifo_q[1];
    if (push) fifo_d[cnt_p[0]] = s2_q;
    cnt_d = cnt_p + {1'b0, push};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      fifo_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      fifo_q <= fifo_d;
    end
  end
  assign in_ready = !rst && !(s1_valid_q && s2_valid_q && cnt_q == 2'd2);
  assign out_valid = s2_valid_q || cnt_q != 2'd0;
  assign out_result = cnt_q != 2'd0 ? fifo_q[0].res : s2_q.res;
  assign out_flags = cnt_q != 2'd0 ? fifo_q[0].flags : s2_q.flags;
`else
  assign s2_en = !s2_valid_q || out_ready;
  assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
  assign out_valid = s2_valid_q;
  assign out_result = s2_q.res;
  assign out_flags = s2_q.flags;
`endif
endmodule
